ks_note_sequencer: RTL and testbench

//   Step sequencer that plays the Karplus-Strong string automatically. Holds a small

---
 rtl/ks_seq_pkg.sv | 15 +
 rtl/ks_seq_step_table.sv | 37 +++
 rtl/ks_note_sequencer.sv | 151 +++++++++++++++
 tb/tb_ks_note_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_seq_pkg.sv
// Shared types and constants for the Karplus-Strong note sequencer.
// Entry layout is {valid, period}; valid=0 marks a rest.
package ks_seq_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ENTRY_W        = DATA_WIDTH_DEF + 1;
    localparam int VALID_BIT      = DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/ks_seq_step_table.sv
// Note table: register file with one write port and one combinational read port.
// A write to the address being read is forwarded so the reader sees the new entry.
module ks_seq_step_table
    import ks_seq_pkg::*;
#(
    parameter  int NUM_STEPS = 8,
    parameter  int WIDTH     = ENTRY_W,
    localparam int SW        = $clog2(NUM_STEPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [SW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [SW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] r_mem [NUM_STEPS];
    logic             w_bypass;

    // NOTE: this table is a handful of flops, not a RAM macro, so clearing it
    // on reset is cheap and guarantees every step starts as a rest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign w_bypass  = wr_en_i && (wr_addr_i == rd_addr_i);
    assign rd_data_o = w_bypass ? wr_data_i : r_mem[rd_addr_i];

endmodule

// File: rtl/ks_note_sequencer.sv
// Step sequencer driving ks_string: walks the note table at a tempo counted in
// sample ticks, presenting each step's period and a stretched pluck request.
module ks_note_sequencer
    import ks_seq_pkg::*;
#(
    parameter  int NUM_STEPS   = 8,
    parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter  int TEMPO_WIDTH = 16,
    parameter  int PLUCK_TICKS = 4,
    localparam int SW          = $clog2(NUM_STEPS),
    localparam int EW          = DATA_WIDTH + 1,
    localparam int PW          = (PLUCK_TICKS > 1) ? $clog2(PLUCK_TICKS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tick_i,
    input  logic                   enable_i,
    input  logic [TEMPO_WIDTH-1:0] tempo_i,
    input  logic [SW-1:0]          last_step_i,
    input  logic                   wr_en_i,
    input  logic [SW-1:0]          wr_addr_i,
    input  logic [EW-1:0]          wr_data_i,
    output logic [DATA_WIDTH-1:0]  period_o,
    output logic                   pluck_o,
    output logic [SW-1:0]          step_o,
    output logic                   step_strobe_o,
    output logic                   busy_o
);

    state_t                 r_state, w_state_nxt;
    logic [SW-1:0]          r_step, w_step_nxt, w_step_adv;
    logic [DATA_WIDTH-1:0]  r_period, w_period_nxt;
    logic                   r_pluck, w_pluck_nxt;
    logic                   r_strobe, r_busy;
    logic [TEMPO_WIDTH-1:0] r_tcnt, w_tcnt_nxt;
    logic [PW-1:0]          r_pcnt, w_pcnt_nxt;
    logic [EW-1:0]          w_entry;
    logic                   w_step_done;

    ks_seq_step_table #(
        .NUM_STEPS (NUM_STEPS),
        .WIDTH     (EW)
    ) u_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (r_step),
        .rd_data_o (w_entry)
    );

    // The >= compare lets a tempo lowered below tcnt end the step on the next tick.
    assign w_step_done = tick_i && (r_tcnt >= tempo_i);
    assign w_step_adv  = (r_step >= last_step_i) ? '0 : r_step + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and process ordering cannot change behaviour.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: each combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable_i) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = enable_i ? PLAY : IDLE;
            PLAY: begin
                if (!enable_i)       w_state_nxt = IDLE;
                else if (w_step_done) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_step_nxt   = r_step;
        w_period_nxt = r_period;
        w_pluck_nxt  = r_pluck;
        w_tcnt_nxt   = r_tcnt;
        w_pcnt_nxt   = r_pcnt;
        case (r_state)
            IDLE: begin
                w_pluck_nxt = 1'b0;
                if (enable_i) w_step_nxt = '0;
            end
            LOAD: begin
                if (!enable_i) begin
                    w_pluck_nxt = 1'b0;
                end else begin
                    w_tcnt_nxt = '0;
                    if (w_entry[DATA_WIDTH]) begin
                        w_period_nxt = w_entry[DATA_WIDTH-1:0];
                        w_pluck_nxt  = 1'b1;
                        w_pcnt_nxt   = PW'(PLUCK_TICKS - 1);
                    end else begin
                        w_pluck_nxt = 1'b0;
                    end
                end
            end
            PLAY: begin
                if (!enable_i) begin
                    w_pluck_nxt = 1'b0;
                end else if (tick_i) begin
                    if (r_pluck && (r_pcnt == '0)) w_pluck_nxt = 1'b0;
                    else if (r_pluck)              w_pcnt_nxt  = r_pcnt - 1'b1;
                    if (w_step_done) begin
                        w_step_nxt  = w_step_adv;
                        w_pluck_nxt = 1'b0;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
            end
            default: w_pluck_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_step   <= '0;
            r_period <= '0;
            r_pluck  <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_tcnt   <= '0;
            r_pcnt   <= '0;
        end else begin
            r_step   <= w_step_nxt;
            r_period <= w_period_nxt;
            r_pluck  <= w_pluck_nxt;
            r_strobe <= (w_state_nxt == LOAD);
            r_busy   <= (w_state_nxt != IDLE);
            r_tcnt   <= w_tcnt_nxt;
            r_pcnt   <= w_pcnt_nxt;
        end
    end

    assign period_o      = r_period;
    assign pluck_o       = r_pluck;
    assign step_o        = r_step;
    assign step_strobe_o = r_strobe;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Scoreboard bench for ks_note_sequencer: stimulus queues the expected step
// sequence, a negedge monitor checks each loaded step and its tick counts.
module tb_ks_note_sequencer;

    localparam int SW = 3;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tick_i;
    logic          enable_i;
    logic [15:0]   tempo_i;
    logic [SW-1:0] last_step_i;
    logic          wr_en_i;
    logic [SW-1:0] wr_addr_i;
    logic [DW:0]   wr_data_i;
    logic [DW-1:0] period_o;
    logic          pluck_o;
    logic [SW-1:0] step_o;
    logic          step_strobe_o;
    logic          busy_o;

    ks_note_sequencer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tick_i        (tick_i),
        .enable_i      (enable_i),
        .tempo_i       (tempo_i),
        .last_step_i   (last_step_i),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .period_o      (period_o),
        .pluck_o       (pluck_o),
        .step_o        (step_o),
        .step_strobe_o (step_strobe_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int step;
        int period;
        int pluck;
        int pl_ticks;   // -1: step not finished, not checked
        int st_ticks;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input int p, input int pl, input int plt, input int stt);
        exp_t e;
        e.step = s; e.period = p; e.pluck = pl; e.pl_ticks = plt; e.st_ticks = stt;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_i = 1'b1;
            cyc();
            tick_i = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic wr(input int addr, input bit valid, input int period);
        wr_en_i   = 1'b1;
        wr_addr_i = SW'(addr);
        wr_data_i = {valid, DW'(period)};
        cyc();
        wr_en_i   = 1'b0;
    endtask

    task automatic start();
        enable_i = 1'b1;
        cyc();
        cyc();
    endtask

    // Monitor: pop on the first PLAY cycle after each LOAD, close tick counts at the next LOAD.
    initial begin
        exp_t cur;
        bit   cur_valid   = 1'b0;
        bit   prev_strobe = 1'b0;
        int   pl_cnt      = 0;
        int   st_cnt      = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                cur_valid   = 1'b0;
                prev_strobe = 1'b0;
            end else begin
                if (step_strobe_o) begin
                    if (cur_valid) begin
                        if (cur.pl_ticks >= 0) check("sb_pluck_ticks", pl_cnt, cur.pl_ticks);
                        if (cur.st_ticks >= 0) check("sb_step_ticks", st_cnt, cur.st_ticks);
                    end
                    cur_valid = 1'b0;
                end else if (prev_strobe && busy_o) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_step", sb_q.size(), 1);
                    end else begin
                        cur = sb_q.pop_front();
                        check("sb_step", step_o, cur.step);
                        check("sb_period", period_o, cur.period);
                        check("sb_pluck", pluck_o, cur.pluck);
                        cur_valid = 1'b1;
                        pl_cnt = 0;
                        st_cnt = 0;
                        if (tick_i) begin
                            st_cnt++;
                            if (pluck_o) pl_cnt++;
                        end
                    end
                end else if (cur_valid && busy_o && tick_i) begin
                    st_cnt++;
                    if (pluck_o) pl_cnt++;
                end
                if (!busy_o) cur_valid = 1'b0;
                prev_strobe = step_strobe_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; tick_i = 1'b0; enable_i = 1'b0; tempo_i = '0;
        last_step_i = '0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        repeat (3) cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_period", period_o, 0);
        check("rst_pluck", pluck_o, 0);
        check("rst_step", step_o, 0);
        check("rst_strobe", step_strobe_o, 0);
        check("rst_busy", busy_o, 0);
        cyc();

        // Basic play: 10 ticks per step, step 2 is a rest
        wr(0, 1'b1, 40);
        wr(1, 1'b1, 30);
        wr(2, 1'b0, 99);
        wr(3, 1'b1, 20);
        tempo_i = 16'd9; last_step_i = 3'd3;
        push(0, 40, 1, 4, 10); push(1, 30, 1, 4, 10); push(2, 30, 0, 0, 10);
        push(3, 20, 1, 4, 10); push(0, 40, 1, 4, 10); push(1, 30, 1, -1, -1);
        start();
        tick(50);
        enable_i = 1'b0;
        cyc(); cyc();

        // tempo 0: one tick per step, pluck cut to one tick
        tempo_i = 16'd0;
        push(0, 40, 1, 1, 1); push(1, 30, 1, 1, 1); push(2, 30, 0, 0, 1);
        push(3, 20, 1, 1, 1); push(0, 40, 1, 1, 1); push(1, 30, 1, -1, -1);
        start();
        tick(5);
        enable_i = 1'b0;
        cyc(); cyc();

        // Tempo lowered below tcnt mid-step, then last_step lowered below step_o
        tempo_i = 16'd20; last_step_i = 3'd7;
        push(0, 40, 1, 4, 8); push(1, 30, 1, 4, 4); push(2, 30, 0, 0, 4);
        push(3, 20, 1, 4, 4); push(4, 20, 0, 0, 4); push(5, 20, 0, 0, 4);
        push(0, 40, 1, 4, 4);
        start();
        tick(7);
        tempo_i = 16'd3;
        tick(1);
        tick(16);
        tick(2);
        last_step_i = 3'd1;
        tick(2);

        // Write step 1 in the very LOAD cycle that reads it, then stop during its pluck
        push(1, 55, 1, -1, -1);
        tick(3);
        tick_i = 1'b1;
        cyc();
        tick_i    = 1'b0;
        wr_en_i   = 1'b1;
        wr_addr_i = 3'd1;
        wr_data_i = {1'b1, 8'd55};
        cyc();
        wr_en_i  = 1'b0;
        enable_i = 1'b0;
        cyc();
        @(negedge clk_i);
        check("stop_pluck", pluck_o, 0);
        check("stop_busy", busy_o, 0);
        check("stop_period_held", period_o, 55);
        check("stop_step_held", step_o, 1);

        // Re-enable restarts at step 0 with the strobe one cycle after enable
        push(0, 40, 1, -1, -1);
        cyc();
        enable_i = 1'b1;
        @(negedge clk_i);
        check("reen_strobe_n", step_strobe_o, 0);
        @(negedge clk_i);
        check("reen_strobe_n1", step_strobe_o, 1);
        check("reen_step", step_o, 0);
        check("reen_busy", busy_o, 1);
        cyc();
        tick(2);

        // Reset while playing clears outputs and the table
        rst_i    = 1'b1;
        enable_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_period", period_o, 0);
        check("midrst_pluck", pluck_o, 0);
        check("midrst_step", step_o, 0);
        check("midrst_strobe", step_strobe_o, 0);
        check("midrst_busy", busy_o, 0);
        cyc();

        tempo_i = 16'd0; last_step_i = 3'd3;
        push(0, 0, 0, 0, 1); push(1, 0, 0, 0, 1); push(2, 0, 0, 0, 1);
        push(3, 0, 0, 0, 1); push(0, 0, 0, 0, 1); push(1, 0, 0, -1, -1);
        start();
        tick(5);
        enable_i = 1'b0;
        repeat (3) cyc();
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
